// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversample tick generator, OFF/RUN/FINISH arming FSM,
// and a small receive FIFO presented as an AXI-Stream master.
module uart_rx_ctrl #(
    parameter int NBITS      = 8,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          clr_overrun,
    output logic                          rx_clk,
    output logic                          start_rx,
    input  logic [NBITS-1:0]              rx_data,
    input  logic                          rx_done,
    output logic [NBITS-1:0]              m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    output logic [1:0]                    fsm_state
);

    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int FIN_TICKS = (NBITS + 2) * 16;
    localparam int FW        = $clog2(FIN_TICKS + 1);

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DIV_W-1:0]  tick_cnt;
    logic [FW-1:0]     fin_cnt;
    logic              fin_expire;

    // FINISH gives up once a whole character's worth of ticks has been seen.
    assign fin_expire = rx_clk && (fin_cnt == FW'(FIN_TICKS - 1));
    assign fsm_state  = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_OFF:    if (enable) state_nxt = S_RUN;
            S_RUN:    if (!enable) state_nxt = S_FINISH;
            S_FINISH: begin
                if (rx_done || fin_expire) state_nxt = S_OFF;
                else if (enable)           state_nxt = S_RUN;
            end
            default:  state_nxt = S_OFF;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_OFF;
            start_rx <= 1'b0;
            rx_clk   <= 1'b0;
            tick_cnt <= '0;
            fin_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            start_rx <= (state_nxt == S_RUN);
            if (state_nxt == S_OFF) begin
                tick_cnt <= '0;
                rx_clk   <= 1'b0;
            end else begin
                rx_clk   <= (tick_cnt == baud_div);
                // A shrunken divisor below the current count wraps silently.
                tick_cnt <= (tick_cnt >= baud_div) ? '0 : tick_cnt + DIV_W'(1);
            end
            fin_cnt <= (state == S_FINISH) ? fin_cnt + FW'(rx_clk) : '0;
        end
    end

    // Stream handshake: a character transfers on every clk edge where m_axis_tvalid
    // and m_axis_tready are both 1; tvalid is driven from the pointers only, never
    // from tready, and tdata holds still until the transfer happens.
    logic [NBITS-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             pop;
    logic             wr_en;
    logic             drop;

    assign fifo_level    = wr_ptr - rd_ptr;
    assign m_axis_tvalid = (wr_ptr != rd_ptr);
    assign full          = (fifo_level == (AW + 1)'(FIFO_DEPTH));
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign wr_en         = rx_done && (!full || pop);
    assign drop          = rx_done && full && !pop;
    assign m_axis_tdata  = mem[rd_ptr[AW-1:0]];

    // When full, a simultaneous pop frees the head slot, which is exactly where wr_ptr points.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= rx_data;
                wr_ptr              <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW + 1)'(1);
            if (drop)             overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: tick/FSM sequences, a FIFO vector table, and a
// queue scoreboard that tracks every accepted character through the stream port.
module tb_uart_rx_ctrl;
    localparam int NBITS = 8;
    localparam int DIV_W = 16;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rstn = 1'b1;
    logic              enable = 1'b0;
    logic [DIV_W-1:0]  baud_div = '0;
    logic              clr_overrun = 1'b0;
    logic              rx_clk;
    logic              start_rx;
    logic [NBITS-1:0]  rx_data = '0;
    logic              rx_done = 1'b0;
    logic [NBITS-1:0]  m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic [2:0]        fifo_level;
    logic              overrun;
    logic [1:0]        fsm_state;

    uart_rx_ctrl #(.NBITS(NBITS), .DIV_W(DIV_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .baud_div(baud_div),
        .clr_overrun(clr_overrun), .rx_clk(rx_clk), .start_rx(start_rx),
        .rx_data(rx_data), .rx_done(rx_done), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .fifo_level(fifo_level), .overrun(overrun), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [NBITS-1:0] exp_q[$];

    typedef struct {
        logic       done;
        logic [7:0] data;
        logic       ready;
        logic       clr;
        logic [2:0] lvl;
        logic       tv;
        logic       ovr;
    } vec_t;

    typedef struct {
        logic [DIV_W-1:0] bd;
        int               period;
    } tick_t;

    vec_t  fifo_tab[25];
    tick_t tick_tab[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic d, input logic [7:0] dat, input logic r,
                                input logic c, input logic [2:0] l, input logic t,
                                input logic o);
        vec_t v;
        v.done = d; v.data = dat; v.ready = r; v.clr = c;
        v.lvl = l; v.tv = t; v.ovr = o;
        return v;
    endfunction

    // One clock of stimulus, called at a negedge; updates the scoreboard first.
    task automatic cycle(input logic done, input logic [7:0] data, input logic ready,
                         input logic clr);
        logic full_m;
        logic pop_m;
        check("tvalid_vs_model", 32'(m_axis_tvalid), 32'(exp_q.size() != 0));
        if (m_axis_tvalid && exp_q.size() != 0)
            check("head_data", 32'(m_axis_tdata), 32'(exp_q[0]));
        full_m = (exp_q.size() == DEPTH);
        pop_m  = ready && m_axis_tvalid;
        if (pop_m && exp_q.size() != 0) void'(exp_q.pop_front());
        if (done && (!full_m || pop_m)) exp_q.push_back(data);
        rx_done = done; rx_data = data; m_axis_tready = ready; clr_overrun = clr;
        @(negedge clk);
        rx_done = 1'b0; clr_overrun = 1'b0; m_axis_tready = 1'b0;
    endtask

    task automatic do_reset();
        enable = 1'b0; rx_done = 1'b0; clr_overrun = 1'b0; m_axis_tready = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int ticks;
        int cyc;
        bit seen;

        fifo_tab[0]  = mk(1'b1, 8'h01, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
        fifo_tab[1]  = mk(1'b1, 8'h02, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
        fifo_tab[2]  = mk(1'b1, 8'h03, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
        fifo_tab[3]  = mk(1'b1, 8'h04, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0);
        fifo_tab[4]  = mk(1'b1, 8'h05, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
        fifo_tab[5]  = mk(1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
        fifo_tab[6]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        fifo_tab[7]  = mk(1'b1, 8'h06, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
        fifo_tab[8]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0);
        fifo_tab[9]  = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0);
        fifo_tab[10] = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
        fifo_tab[11] = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        fifo_tab[12] = mk(1'b1, 8'h21, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
        fifo_tab[13] = mk(1'b1, 8'h22, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
        fifo_tab[14] = mk(1'b1, 8'h23, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
        fifo_tab[15] = mk(1'b1, 8'h24, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0);
        fifo_tab[16] = mk(1'b1, 8'h25, 1'b0, 1'b1, 3'd4, 1'b1, 1'b1);
        fifo_tab[17] = mk(1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
        fifo_tab[18] = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0);
        fifo_tab[19] = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0);
        fifo_tab[20] = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
        fifo_tab[21] = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        fifo_tab[22] = mk(1'b1, 8'h31, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
        fifo_tab[23] = mk(1'b1, 8'h32, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
        fifo_tab[24] = mk(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

        tick_tab[0] = '{bd: 16'd0, period: 1};
        tick_tab[1] = '{bd: 16'd1, period: 2};
        tick_tab[2] = '{bd: 16'd3, period: 4};
        tick_tab[3] = '{bd: 16'd5, period: 6};

        // Reset values, checked while rstn is low and before any clock edge.
        #2 rstn = 1'b0;
        #1;
        check("rst_rx_clk", 32'(rx_clk), 32'(0));
        check("rst_start_rx", 32'(start_rx), 32'(0));
        check("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
        check("rst_level", 32'(fifo_level), 32'(0));
        check("rst_overrun", 32'(overrun), 32'(0));
        check("rst_tdata", 32'(m_axis_tdata), 32'(0));
        check("rst_state", 32'(fsm_state), 32'(0));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Tick period and start_rx timing for several divisors.
        foreach (tick_tab[t]) begin
            do_reset();
            baud_div = tick_tab[t].bd;
            enable = 1'b1;
            check("start_rx_before_edge", 32'(start_rx), 32'(0));
            for (int k = 1; k <= 12; k++) begin
                @(negedge clk);
                if (k == 1) begin
                    check("start_rx_after_enable", 32'(start_rx), 32'(1));
                    check("state_run", 32'(fsm_state), 32'(1));
                end
                check("tick_pattern", 32'(rx_clk), 32'((k % tick_tab[t].period) == 0));
            end
        end

        // Divisor shrinks below the running count: wrap without a tick.
        do_reset();
        baud_div = 16'd7;
        enable = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = rx_clk;
        end
        check("first_tick_seen", 32'(seen), 32'(1));
        repeat (5) @(negedge clk);
        baud_div = 16'd2;
        for (int j = 6; j <= 12; j++) begin
            @(negedge clk);
            check("div_change_tick", 32'(rx_clk), 32'(j == 9 || j == 12));
        end

        // Enable dropped, no rx_done: FINISH times out after (NBITS+2)*16 ticks.
        do_reset();
        baud_div = 16'd0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("finish_state", 32'(fsm_state), 32'(2));
        check("finish_start_rx", 32'(start_rx), 32'(0));
        check("finish_ticking", 32'(rx_clk), 32'(1));
        ticks = 0;
        for (cyc = 0; cyc < 1000 && fsm_state == 2'd2; cyc++) begin
            if (rx_clk) ticks++;
            @(negedge clk);
        end
        check("finish_exit_off", 32'(fsm_state), 32'(0));
        check("finish_tick_count", 32'(ticks), 32'(160));
        check("off_rx_clk", 32'(rx_clk), 32'(0));

        // Enable dropped, rx_done arrives: byte stored and FSM goes OFF.
        enable = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        repeat (4) @(negedge clk);
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        check("done_to_off", 32'(fsm_state), 32'(0));
        check("done_stored_level", 32'(fifo_level), 32'(1));
        check("done_stored_data", 32'(m_axis_tdata), 32'(8'h5A));
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("done_drained", 32'(fifo_level), 32'(0));

        // FINISH returns to RUN when enable comes back.
        enable = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("finish_to_run", 32'(fsm_state), 32'(1));
        check("finish_to_run_start", 32'(start_rx), 32'(1));

        // Two characters streamed straight through with tready high.
        do_reset();
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        check("stream_a5_valid", 32'(m_axis_tvalid), 32'(1));
        check("stream_a5_data", 32'(m_axis_tdata), 32'(8'hA5));
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h3C, 1'b1, 1'b0);
        check("stream_3c_valid", 32'(m_axis_tvalid), 32'(1));
        check("stream_3c_data", 32'(m_axis_tdata), 32'(8'h3C));
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        check("stream_level_zero", 32'(fifo_level), 32'(0));

        // FIFO vector table: fill, overflow, clear, full push+pop, drain.
        do_reset();
        foreach (fifo_tab[i]) begin
            cycle(fifo_tab[i].done, fifo_tab[i].data, fifo_tab[i].ready, fifo_tab[i].clr);
            check($sformatf("tab%0d_level", i), 32'(fifo_level), 32'(fifo_tab[i].lvl));
            check($sformatf("tab%0d_tvalid", i), 32'(m_axis_tvalid), 32'(fifo_tab[i].tv));
            check($sformatf("tab%0d_overrun", i), 32'(overrun), 32'(fifo_tab[i].ovr));
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        // Asynchronous reset with entries queued clears outputs before any edge.
        do_reset();
        baud_div = 16'd0;
        enable = 1'b1;
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h12, 1'b0, 1'b0);
        cycle(1'b1, 8'h13, 1'b0, 1'b0);
        check("pre_reset_level", 32'(fifo_level), 32'(3));
        check("pre_reset_tick", 32'(rx_clk), 32'(1));
        #2 rstn = 1'b0;
        #1;
        check("async_rst_tvalid", 32'(m_axis_tvalid), 32'(0));
        check("async_rst_level", 32'(fifo_level), 32'(0));
        check("async_rst_rx_clk", 32'(rx_clk), 32'(0));
        check("async_rst_start_rx", 32'(start_rx), 32'(0));
        check("async_rst_state", 32'(fsm_state), 32'(0));
        exp_q.delete();
        enable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
